// File: rtl/tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tx_scheduler_pkg
// Shared constants for the timestamp transmit scheduler:
//   - FSM state encodings (IDLE, LOAD, WAIT_BUSY, WAIT_DONE)
//   - channel-id field width carried in the top bits of every word
//   - default transmitter busy-acknowledge timeout
//   - saturating adder used by the optional drop counter
// ---------------------------------------------------------------------------
package tx_scheduler_pkg;

  localparam int CH_ID_W           = 4;
  localparam int BUSY_TIMEOUT_DFLT = 16;
  localparam int DROP_CNT_W        = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Add two counter values, pinning the result at all-ones on overflow.
  function automatic logic [DROP_CNT_W-1:0] sat_add(
    input logic [DROP_CNT_W-1:0] base,
    input logic [DROP_CNT_W-1:0] inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum[DROP_CNT_W]) begin
      return {DROP_CNT_W{1'b1}};
    end else begin
      return sum[DROP_CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the first requesting index
// at or after ptr, wrapping modulo N. Usable for any shared resource.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  index with highest priority this cycle
//   grant out IDX_W  chosen index (0 when nothing requests)
//   valid out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] lo_idx_s;
  logic [IDX_W-1:0] hi_idx_s;
  logic             hi_v_s;

  // Scan downwards so the lowest matching index wins: lo_* is the wrap-around
  // fallback, hi_* the first request at or after the pointer.
  always_comb begin
    lo_idx_s = '0;
    hi_idx_s = '0;
    hi_v_s   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      lo_idx_s = req[i] ? IDX_W'(i) : lo_idx_s;
      hi_idx_s = (req[i] && (i >= int'(ptr))) ? IDX_W'(i) : hi_idx_s;
      hi_v_s   = (req[i] && (i >= int'(ptr))) ? 1'b1 : hi_v_s;
    end
    grant = hi_v_s ? hi_idx_s : lo_idx_s;
    valid = |req;
  end

endmodule

// File: rtl/tx_scheduler.sv
// ---------------------------------------------------------------------------
// tx_scheduler
// Captures the shared microsecond counter per sensor channel and hands the
// pending words round-robin to a single serial transmitter (start/busy).
// Build option: define TX_SCHED_DROP_COUNT_EN to add the drop_count output.
// Ports:
//   clk        in   1         system clock
//   rst        in   1         asynchronous active-low reset
//   capture    in   CHANNELS  per-channel single-cycle edge pulses
//   timestamp  in   64        free-running counter
//   tx_busy    in   1         transmitter busy
//   tx_data    out  64        {channel id, timestamp} presented to transmitter
//   tx_start   out  1         one-cycle transmit request
//   pending    out  CHANNELS  holding register valid flags
//   active     out  1         scheduler not idle
//   overrun    out  1         sticky: capture dropped or transfer timed out
//   drop_count out  16        saturating drop counter (option only)
// ---------------------------------------------------------------------------
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TS_WIDTH     = 64 - CH_ID_W,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] capture,
  input  logic [63:0]         timestamp,
  input  logic                tx_busy,
  output logic [63:0]         tx_data,
  output logic                tx_start,
  output logic [CHANNELS-1:0] pending,
  output logic                active,
  output logic                overrun
`ifdef TX_SCHED_DROP_COUNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [CH_ID_W-1:0]  grant_r;
  logic [CH_ID_W-1:0]  ptr_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic                active_r;
  logic [CHANNELS-1:0] pending_r;
  logic [TS_WIDTH-1:0] hold_r [CHANNELS];
  logic [63:0]         tx_data_r;
  logic                tx_start_r;
  logic                overrun_r;

  logic [CH_ID_W-1:0]  arb_grant_s;
  logic                arb_valid_s;
  logic                load_s;
  logic                timeout_s;
  logic [CHANNELS-1:0] clear_s;
  logic [CHANNELS-1:0] latch_s;
  logic [CHANNELS-1:0] drop_s;
  logic [TS_WIDTH-1:0] sel_hold_s;
  logic                unused_ts_s;

  // Only the low TS_WIDTH counter bits are kept; the id field replaces the rest.
  assign unused_ts_s = ^timestamp[63:TS_WIDTH];

  rr_arbiter #(
    .N     (CHANNELS),
    .IDX_W (CH_ID_W)
  ) u_arb (
    .req   (pending_r),
    .ptr   (ptr_r),
    .grant (arb_grant_s),
    .valid (arb_valid_s)
  );

  assign load_s    = (state_r == ST_LOAD);
  assign timeout_s = (state_r == ST_WAIT_BUSY) && !tx_busy &&
                     (to_cnt_r == TO_W'(BUSY_TIMEOUT - 1));
  // A capture landing on the channel being loaded refills it instead of
  // counting as an overrun: the old word has already been taken.
  assign latch_s   = capture & (~pending_r | clear_s);
  assign drop_s    = capture & pending_r & ~clear_s;

  // Decode the granted channel into a clear strobe and select its word.
  always_comb begin
    clear_s    = '0;
    sel_hold_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clear_s[i] = load_s && (grant_r == CH_ID_W'(i));
      sel_hold_s = (grant_r == CH_ID_W'(i)) ? hold_r[i] : sel_hold_s;
    end
  end

  // Next-state logic of the transfer FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched grant, round-robin pointer and busy timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      grant_r  <= '0;
      ptr_r    <= '0;
      to_cnt_r <= '0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      active_r <= (state_nxt_s != ST_IDLE);
      // Freeze the decision so captures arriving during LOAD cannot re-steer it.
      if ((state_r == ST_IDLE) && arb_valid_s) begin
        grant_r <= arb_grant_s;
      end
      if (load_s) begin
        ptr_r <= (grant_r == CH_ID_W'(CHANNELS - 1)) ? '0 : grant_r + CH_ID_W'(1);
      end
      if (state_r == ST_WAIT_BUSY) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

  // Holding registers, pending flags and the registered transmitter interface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r  <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      overrun_r  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      pending_r  <= latch_s | (pending_r & ~clear_s);
      tx_start_r <= load_s;
      overrun_r  <= overrun_r | (|drop_s) | timeout_s;
      for (int i = 0; i < CHANNELS; i++) begin
        if (latch_s[i]) begin
          hold_r[i] <= timestamp[TS_WIDTH-1:0];
        end
      end
      // Sampled from the pre-update hold, so a coincident capture is not sent here.
      if (load_s) begin
        tx_data_r <= {grant_r, sel_hold_s};
      end
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_start = tx_start_r;
  assign pending  = pending_r;
  assign active   = active_r;
  assign overrun  = overrun_r;

`ifdef TX_SCHED_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_count_r;
  logic [DROP_CNT_W-1:0] drop_inc_s;

  assign drop_inc_s = DROP_CNT_W'($countones(drop_s)) + DROP_CNT_W'(timeout_s);

  // Saturating count of every lost word, several per cycle allowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count_r <= '0;
    end else begin
      drop_count_r <= sat_add(drop_count_r, drop_inc_s);
    end
  end

  assign drop_count = drop_count_r;
`endif

endmodule

// File: tb/tb_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_scheduler
// Self-checking bench for tx_scheduler (CHANNELS=4, TS_WIDTH=60, timeout 16).
// A cycle table covers the single-capture transfer; hand-written sequences
// cover round-robin, overrun, timeout, coincident capture and async reset.
// Expected transmit words go into a queue and are popped on every tx_start.
// ---------------------------------------------------------------------------
module tb_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  capture;
  logic [63:0] timestamp;
  logic        man_busy;
  logic        auto_busy;
  logic        resp_en;
  int          busy_len;
  logic        tx_busy;
  logic [63:0] tx_data;
  logic        tx_start;
  logic [3:0]  pending;
  logic        active;
  logic        overrun;
`ifdef TX_SCHED_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb [$];

  typedef struct {
    logic [3:0]  cap;
    logic [63:0] ts;
    logic        busy;
    logic [3:0]  pend;
    logic        start;
    logic        act;
    logic        ovr;
    logic [63:0] data;
    logic        chk_data;
  } vec_t;

  vec_t vecs [14];

  assign tx_busy = resp_en ? auto_busy : man_busy;

  tx_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .timestamp  (timestamp),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .pending    (pending),
    .active     (active),
    .overrun    (overrun)
`ifdef TX_SCHED_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int ch, input logic [63:0] ts);
    logic [3:0] id;
    id = 4'(ch);
    return {id, ts[59:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cap_pulse(input logic [3:0] c, input logic [63:0] t);
    @(negedge clk);
    capture   = c;
    timestamp = t;
    @(negedge clk);
    capture   = 4'b0000;
  endtask

  task automatic wait_start(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = tx_start;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = !active && (pending == 4'b0000) && !tx_busy && (sb.size() == 0);
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    capture = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] w1;
    logic [63:0] t2;
    rst       = 1'b1;
    capture   = 4'b0000;
    timestamp = 64'h0;
    man_busy  = 1'b0;
    auto_busy = 1'b0;
    resp_en   = 1'b0;
    busy_len  = 2;

    fork
      // Scoreboard: every tx_start must present the oldest expected word.
      forever begin
        @(negedge clk);
        if (tx_start) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_word: got %h expected no transfer", tx_data);
          end else begin
            chk("tx_word", tx_data, sb.pop_front());
          end
        end
      end
      // Transmitter model: raises busy on tx_start and holds it busy_len cycles.
      forever begin
        @(negedge clk);
        if (resp_en && tx_start) begin
          auto_busy = 1'b1;
          repeat (busy_len) @(negedge clk);
          auto_busy = 1'b0;
        end
      end
    join_none

    // Reset state, taken asynchronously before any clock edge.
    #1 rst = 1'b0;
    #2;
    chk("rst_tx_data", tx_data, 64'h0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    do_reset();

    // ---- single capture on ch2, cycle table ----
    w1 = 64'h2000_0000_0000_1234;
    for (int k = 0; k < 14; k++) begin
      vecs[k].cap = 4'b0000; vecs[k].ts = 64'h0; vecs[k].busy = 1'b0;
      vecs[k].pend = 4'b0000; vecs[k].start = 1'b0; vecs[k].act = 1'b1;
      vecs[k].ovr = 1'b0; vecs[k].data = w1; vecs[k].chk_data = 1'b1;
    end
    vecs[0].cap = 4'b0100; vecs[0].ts = 64'h1234; vecs[0].pend = 4'b0100;
    vecs[0].act = 1'b0; vecs[0].data = 64'h0;
    vecs[1].pend = 4'b0100; vecs[1].data = 64'h0;
    vecs[2].start = 1'b1;
    for (int k = 3; k < 13; k++) vecs[k].busy = 1'b1;
    vecs[13].act = 1'b0; vecs[13].chk_data = 1'b0;
    sb.push_back(w1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      capture   = vecs[k].cap;
      timestamp = vecs[k].ts;
      man_busy  = vecs[k].busy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pending", k), 64'(pending), 64'(vecs[k].pend));
      chk($sformatf("vec%0d_tx_start", k), 64'(tx_start), 64'(vecs[k].start));
      chk($sformatf("vec%0d_active", k), 64'(active), 64'(vecs[k].act));
      chk($sformatf("vec%0d_overrun", k), 64'(overrun), 64'(vecs[k].ovr));
      if (vecs[k].chk_data) chk($sformatf("vec%0d_tx_data", k), tx_data, vecs[k].data);
    end
    wait_drain("single_drain");

    // ---- round-robin: all four at once from pointer 0 ----
    do_reset();
    resp_en  = 1'b1;
    busy_len = 2;
    t2 = 64'hFEDC_BA98_7654_3210;
    for (int i = 0; i < 4; i++) sb.push_back(word(i, t2));
    cap_pulse(4'b1111, t2);
    chk("rr_pending_all", 64'(pending), 64'hF);
    wait_drain("rr_drain");
    // Pointer must have wrapped to 0: ch0 goes before ch3.
    sb.push_back(word(0, 64'h55));
    sb.push_back(word(3, 64'h55));
    cap_pulse(4'b1001, 64'h55);
    wait_drain("rr_wrap_drain");
    chk("rr_overrun", 64'(overrun), 64'd0);

    // ---- overrun: second ch1 capture while ch0 holds the transmitter ----
    do_reset();
    busy_len = 20;
    sb.push_back(word(0, 64'h0A0A));
    cap_pulse(4'b0001, 64'h0A0A);
    wait_start("ovr_ch0_start");
    sb.push_back(word(1, 64'h0B0B));
    cap_pulse(4'b0010, 64'h0B0B);
    chk("ovr_first_pending", 64'(pending), 64'h2);
    chk("ovr_first_flag", 64'(overrun), 64'd0);
    cap_pulse(4'b0010, 64'h0C0C);
    chk("ovr_second_pending", 64'(pending), 64'h2);
    chk("ovr_second_flag", 64'(overrun), 64'd1);
`ifdef TX_SCHED_DROP_COUNT_EN
    chk("ovr_drop_count", 64'(drop_count), 64'd1);
`endif
    wait_drain("ovr_drain");
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // ---- timeout: busy never rises for ch0, ch1 follows ----
    do_reset();
    resp_en  = 1'b0;
    man_busy = 1'b0;
    sb.push_back(word(0, 64'hF123_4567_89AB_CDEF));
    sb.push_back(word(1, 64'hF123_4567_89AB_CDEF));
    cap_pulse(4'b0011, 64'hF123_4567_89AB_CDEF);
    wait_start("to_ch0_start");
    repeat (15) @(negedge clk);
    chk("to_active_before", 64'(active), 64'd1);
    chk("to_overrun_before", 64'(overrun), 64'd0);
    @(negedge clk);
    chk("to_active_after", 64'(active), 64'd0);
    chk("to_overrun_after", 64'(overrun), 64'd1);
    chk("to_pending_ch1", 64'(pending), 64'h2);
    resp_en  = 1'b1;
    busy_len = 2;
    @(negedge clk);
    @(negedge clk);
    chk("to_ch1_start", 64'(tx_start), 64'd1);
    wait_drain("to_drain");
`ifdef TX_SCHED_DROP_COUNT_EN
    chk("to_drop_count", 64'(drop_count), 64'd1);
`endif

    // ---- capture of ch0 in its own LOAD cycle ----
    do_reset();
    busy_len = 3;
    sb.push_back(word(0, 64'h0F0F));
    sb.push_back(word(0, 64'h0606));
    @(negedge clk); capture = 4'b0001; timestamp = 64'h0F0F;
    @(negedge clk); capture = 4'b0000;
    @(negedge clk); capture = 4'b0001; timestamp = 64'h0606;
    @(negedge clk); capture = 4'b0000;
    chk("coin_tx_start", 64'(tx_start), 64'd1);
    chk("coin_pending", 64'(pending), 64'h1);
    wait_drain("coin_drain");
    chk("coin_overrun", 64'(overrun), 64'd0);

    // ---- asynchronous reset during WAIT_DONE ----
    do_reset();
    busy_len = 10;
    sb.push_back(word(3, 64'h7777));
    cap_pulse(4'b1000, 64'h7777);
    wait_start("ar_start");
    cap_pulse(4'b1000, 64'h8888);
    cap_pulse(4'b1000, 64'h9999);
    chk("ar_pre_active", 64'(active), 64'd1);
    chk("ar_pre_overrun", 64'(overrun), 64'd1);
`ifdef TX_SCHED_DROP_COUNT_EN
    chk("ar_pre_drop_count", 64'(drop_count), 64'd1);
`endif
    #2 rst = 1'b0;
    #1;
    chk("ar_tx_data", tx_data, 64'h0);
    chk("ar_tx_start", 64'(tx_start), 64'd0);
    chk("ar_pending", 64'(pending), 64'd0);
    chk("ar_active", 64'(active), 64'd0);
    chk("ar_overrun", 64'(overrun), 64'd0);
`ifdef TX_SCHED_DROP_COUNT_EN
    chk("ar_drop_count", 64'(drop_count), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    wait_drain("ar_drain");
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Multi-channel timestamp scheduler in front of the serial data transmitter.
- Each sensor channel's edge pulse captures the shared 64-bit microsecond counter into a per-channel holding register.
- Pending words are granted round-robin to the single transmitter via a start/busy handshake.
- Sits between edge detectors/counter and the transmitter; drives the status LEDs (active, overrun).

Parameters:
- CHANNELS, 4, number of sensor channels (2..8).
- TS_WIDTH, 60, timestamp bits kept per word; must be 64 minus the channel-id width (4).
- BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before abandoning the word.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- capture  in  CHANNELS  per-channel single-cycle edge pulses.
- timestamp  in  64  free-running counter value.
- tx_busy  in  1  transmitter busy.
- tx_data  out  64  word presented to the transmitter.
- tx_start  out  1  one-cycle transmit request.
- pending  out  CHANNELS  holding register valid flags.
- active  out  1  FSM not in IDLE.
- overrun  out  1  sticky: a capture hit an already pending channel.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, holding registers 0, round-robin pointer 0, FSM IDLE.
- Capture, per channel i:
  - capture[i] with pending[i]=0: latch timestamp[TS_WIDTH-1:0] into hold[i]; pending[i]=1 next cycle.
  - capture[i] with pending[i]=1: new value dropped, old kept; overrun set (sticky until reset).
- Word format: tx_data = {4'(channel id), hold[TS_WIDTH-1:0]}.
- FSM IDLE: if any pending, choose the first pending channel at or after the pointer (wrap modulo CHANNELS) -> LOAD.
- FSM LOAD (1 cycle):
  - tx_data registered from the granted hold; tx_start=1; pending[g] cleared; pointer = g+1 mod CHANNELS.
  - -> WAIT_BUSY.
- FSM WAIT_BUSY: tx_busy=1 -> WAIT_DONE; timeout counter reaches BUSY_TIMEOUT -> IDLE (word lost, overrun set).
- FSM WAIT_DONE: tx_busy=0 -> IDLE.
- tx_data is held stable from LOAD until the FSM returns to IDLE.
- Latency: capture to tx_start is 3 cycles minimum (latch, IDLE decision, LOAD).
- Simultaneous capture[g] and LOAD of g: the clear and the new latch coincide. The new value is stored and pending[g] stays 1. tx_data carries the old value, because it is sampled before the update.
- Multiple simultaneous captures: all latched in the same cycle, then served in round-robin order.
- Reset mid-transfer: FSM returns to IDLE immediately; the transmitter is expected to be reset by the same rst.

Optional Feature:
- Macro: TX_SCHED_DROP_COUNT_EN.
- Defined: adds output drop_count[15:0].
  - Saturating at 16'hFFFF.
  - Increments once per dropped capture or timeout.
  - Drops in the same cycle add their total (capped).
  - Reset value 0.
- Undefined: port absent; only the sticky overrun flag exists.

Decomposition:
- Shared constants file gets:
  - FSM state encodings (IDLE=0, LOAD=1, WAIT_BUSY=2, WAIT_DONE=3).
  - Channel-id width (4).
  - Default BUSY_TIMEOUT.
- One sub-module rr_arbiter: combinational pending vector plus pointer in, grant index and valid out. Reusable for other shared resources.

Test Plan:
- Single capture: capture[2] with timestamp=64'h1234 -> tx_start 3 cycles later, tx_data=64'h2000_0000_0000_1234. Hold tx_busy high 10 cycles, then low -> active falls next cycle.
- Round-robin: capture=4'b1111 in one cycle, pointer 0 -> words sent in order ch0, ch1, ch2, ch3; pointer ends at 0.
- Overrun: capture[1] twice while the transmitter is held busy by ch0 -> second value dropped, overrun=1, first ch1 value transmitted.
- Timeout: tx_busy stuck low after tx_start -> FSM returns to IDLE after 16 cycles, overrun=1, next pending word proceeds.
- Coincident capture and grant: capture[0] in the LOAD cycle of ch0 -> old value transmitted, new value sent in the next transfer.
- Async reset mid-WAIT_DONE: rst low between clock edges -> all outputs 0 without a clock edge. With TX_SCHED_DROP_COUNT_EN, drop_count=0.
